// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between the 8-deep byte FIFO and the UART transmitter.
//
// Signals:
//   fifo_rd_en : read pulse from the consumer; one cycle pops one byte
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO data_out; registered, valid the cycle after fifo_rd_en
//
// Modports:
//   master : the consumer (fifo_uart_tx) that issues reads
//   slave  : the FIFO that answers them
interface fifo_uart_tx_if;
    logic       fifo_rd_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from the read side of the byte FIFO. Pops one byte per
// frame and sends start bit, 8 data bits LSB first, an optional parity bit and
// one or two stop bits.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//   STOP_BITS    : 1 or 2
//   PARITY       : 0 none, 1 even, 2 odd
//
// Ports:
//   clk        : single clock, all logic on posedge
//   reset      : asynchronous, active-high
//   tx_en      : permission to start a new frame (looked at in IDLE and on the
//                last stop cycle only)
//   fifo       : FIFO read bundle (master side)
//   tx         : serial line, idle high
//   busy       : high in every state except IDLE
//   frame_done : one-cycle pulse on the last clk of the final stop bit
//
// States:
//   S_IDLE   | line idle, waiting for tx_en && !fifo_empty
//   S_FETCH  | fifo_rd_en high for this single cycle
//   S_LOAD   | FIFO output now valid: capture byte, compute parity
//   S_START  | start bit (tx=0)
//   S_DATA   | data bits, LSB first, shift register moves right per bit
//   S_PARITY | parity bit (only reachable when PARITY != 0)
//   S_STOP   | stop bit(s); may chain straight into S_FETCH
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int            TW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q,    state_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic          parity_q,   parity_d;

    logic bit_tick;
    logic stop_last;
    logic can_start;

    // Bit timer wraps at CLKS_PER_BIT-1; stop_idx extends it over a second
    // stop bit when configured.
    assign bit_tick  = (timer_q == T_LAST);
    assign stop_last = (STOP_BITS == 2) ? stop_idx_q : 1'b1;
    assign can_start = tx_en && !fifo.fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;

        case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                // Parity is taken from the whole byte here, before shifting
                // destroys it.
                shift_d    = fifo.fifo_data;
                parity_d   = (PARITY == 2) ? ~^fifo.fifo_data : ^fifo.fifo_data;
                timer_d    = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                state_d    = S_START;
            end

            S_START: begin
                if (bit_tick) begin
                    timer_d = '0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    timer_d   = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_tick) begin
                    timer_d = '0;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_tick) begin
                    timer_d = '0;
                    if (stop_last) begin
                        stop_idx_d = 1'b0;
                        // Chaining into FETCH here gives exactly two idle-high
                        // cycles (FETCH, LOAD) between frames.
                        state_d    = can_start ? S_FETCH : S_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so they cannot glitch on input
    // changes, and reset forces them to idle values immediately.
    always_comb begin
        tx              = 1'b1;
        fifo.fifo_rd_en = (state_q == S_FETCH);
        busy            = (state_q != S_IDLE);
        frame_done      = (state_q == S_STOP) && bit_tick && stop_last;

        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = parity_q;
            default:  tx = 1'b1;
        endcase
    end

endmodule
